// File: rtl/sa_ctrl.sv
// sa_ctrl -- sequencing controller for the output-stationary systolic array.
//
// Runs one job per accepted start: clear the PE accumulators, stream k_len
// operand vectors (valid/ready), flush the skew pipeline with zero operands,
// prime the array's channel-output counter, then drain N channels to
// writeback one per out_ready handshake.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   start, cfg_mode,  job request (sampled in IDLE only) and its configuration
//   cfg_k_len
//   abort             synchronous job kill (ignored in IDLE)
//   in_valid/in_ready operand-buffer handshake
//   out_ready         writeback accepts the presented channel
//   sa_en, sa_mode, sa_reset, sa_ch_reset, sa_ch_en, zero_in   array controls
//   out_valid, out_idx  channel presented to writeback
//   busy, done        job status
module sa_ctrl #(
    parameter int N      = 32,
    parameter int K_W    = 16,
    parameter int PE_LAT = 1,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cfg_mode,
    input  logic [K_W-1:0]   cfg_k_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             sa_en,
    output logic             sa_mode,
    output logic             sa_reset,
    output logic             sa_ch_reset,
    output logic             sa_ch_en,
    output logic             zero_in,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    // Skew flush: operands need 2*(N-1) cycles to cross the grid, plus PE latency.
    localparam int F   = 2 * (N - 1) + PE_LAT;
    localparam int F_W = (F > 1) ? $clog2(F + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_PRIME, S_DRAIN, S_DONE
    } state_t;

    state_t             state, state_n;
    logic               mode_q;
    logic [K_W-1:0]     k_len_q;
    logic [K_W-1:0]     beat_cnt;
    logic [F_W-1:0]     flush_cnt;
    logic [IDX_W-1:0]   idx_q;
    logic               ov_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        in_ready    = 1'b0;
        sa_en       = 1'b0;
        sa_reset    = 1'b0;
        sa_ch_reset = 1'b0;
        sa_ch_en    = 1'b0;
        zero_in     = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = S_CLEAR;
            S_CLEAR: begin
                sa_reset    = 1'b1;
                sa_ch_reset = 1'b1;
                state_n     = (k_len_q == '0) ? S_FLUSH : S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                // Array only advances on a real vector so gaps cannot skew the wavefront.
                sa_en    = in_valid;
                if (in_valid && beat_cnt == k_len_q - 1'b1) state_n = S_FLUSH;
            end
            S_FLUSH: begin
                sa_en   = 1'b1;
                zero_in = 1'b1;
                if (flush_cnt == F_W'(F - 1)) state_n = S_PRIME;
            end
            S_PRIME: begin
                // Moves the array's channel counter from -1 to channel 0.
                sa_ch_en = 1'b1;
                state_n  = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(N - 1)) begin
                        sa_ch_reset = 1'b1;
                        state_n     = S_DONE;
                    end else begin
                        sa_ch_en = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides everything else in the cycle it is seen.
        if (abort && state != S_IDLE) begin
            state_n     = S_IDLE;
            in_ready    = 1'b0;
            sa_en       = 1'b0;
            sa_reset    = 1'b0;
            sa_ch_en    = 1'b0;
            zero_in     = 1'b0;
            done        = 1'b0;
            sa_ch_reset = 1'b1;
        end
    end

    logic kill;
    assign kill      = abort && (state != S_IDLE);
    assign busy      = (state != S_IDLE) && !kill;
    assign sa_mode   = busy && mode_q;
    assign out_valid = ov_q && !kill;
    assign out_idx   = kill ? '0 : idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= 1'b0;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            idx_q     <= '0;
            ov_q      <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                mode_q  <= cfg_mode;
                k_len_q <= cfg_k_len;
            end
            // Beat count tops out at k_len, so k_len = 2^K_W-1 never wraps.
            if (state == S_FEED) begin
                if (in_valid && !abort) beat_cnt <= beat_cnt + 1'b1;
            end else begin
                beat_cnt <= '0;
            end
            if (state == S_FLUSH && !abort) flush_cnt <= flush_cnt + 1'b1;
            else                            flush_cnt <= '0;
            if (state == S_DRAIN && state_n == S_DRAIN && out_ready)
                idx_q <= idx_q + 1'b1;
            else if (state_n != S_DRAIN)
                idx_q <= '0;
            ov_q <= (state_n == S_DRAIN);
        end
    end

endmodule

// File: tb/tb_sa_ctrl.sv
// Bench for sa_ctrl (N=4, PE_LAT=1, F=7). Expected drain indices are queued
// when a job is launched and popped on every out_valid&out_ready handshake;
// per-job cycle stats are gathered by a negedge monitor relative to the
// cycle start was sampled.
module tb_sa_ctrl;
    localparam int N = 4, K_W = 8, PE_LAT = 1, IDX_W = 2;
    localparam int F = 2 * (N - 1) + PE_LAT;

    logic clk = 1'b0, reset = 1'b0;
    logic start = 0, cfg_mode = 0, abort = 0, in_valid = 0, out_ready = 0;
    logic [K_W-1:0] cfg_k_len = '0;
    logic in_ready, sa_en, sa_mode, sa_reset, sa_ch_reset, sa_ch_en, zero_in;
    logic out_valid, busy, done;
    logic [IDX_W-1:0] out_idx;

    sa_ctrl #(.N(N), .K_W(K_W), .PE_LAT(PE_LAT), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
        .cfg_k_len(cfg_k_len), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .out_ready(out_ready), .sa_en(sa_en),
        .sa_mode(sa_mode), .sa_reset(sa_reset), .sa_ch_reset(sa_ch_reset),
        .sa_ch_en(sa_ch_en), .zero_in(zero_in), .out_valid(out_valid),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, t0 = 0;
    int vpat = 0, stall_left = 0;
    logic exp_mode = 0;
    int exp_q[$];
    int first_rst, first_ch, en_cnt, beats, en_bad, ch_bad, hs, mode_bad, done_rel;
    int done_total = 0;
    bit done_seen = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [IDX_W+9:0] all_outs();
        return {in_ready, sa_en, sa_mode, sa_reset, sa_ch_reset, sa_ch_en,
                zero_in, out_valid, busy, done, out_idx};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Input driver: valid pattern relative to job start, out_ready stall at channel 2.
    always @(posedge clk) begin
        #1;
        in_valid = (vpat != 0) ? (((cyc - t0) % 2) == 1) : 1'b1;
        if (stall_left > 0 && out_valid && out_idx == 2) begin
            out_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        int rel;
        if (reset && start && !busy) begin
            t0 = cyc; first_rst = -1; first_ch = -1; en_cnt = 0; beats = 0;
            en_bad = 0; ch_bad = 0; hs = 0; mode_bad = 0; done_rel = -1;
            done_seen = 0;
        end
        rel = cyc - t0;
        if (sa_reset && first_rst < 0) first_rst = rel;
        if (sa_en) en_cnt++;
        if (in_ready && in_valid) beats++;
        if (in_ready && !in_valid && sa_en) en_bad++;
        if (sa_ch_en) begin
            en_cnt = en_cnt;
            if (first_ch < 0) first_ch = rel;
        end
        if (out_valid && !out_ready && sa_ch_en) ch_bad++;
        if (out_valid && out_ready) begin
            hs++;
            if (exp_q.size() == 0) chk("sb_extra", 1, 0);
            else                   chk("drain_idx", out_idx, exp_q.pop_front());
        end
        if (busy && sa_mode !== exp_mode) mode_bad++;
        if (done) begin done_seen = 1; done_rel = rel; done_total++; end
    end

    int ch_cnt = 0;
    always @(negedge clk) if (sa_ch_en) ch_cnt++;

    task automatic issue_start(input int k, input bit m, input bit abt);
        @(posedge clk); #1;
        cfg_k_len = K_W'(k); cfg_mode = m; exp_mode = m; start = 1; abort = abt;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        @(posedge clk); #1;
        start = 0; abort = 0;
    endtask

    task automatic finish_job(input string nm, input int k, input int stl, input int exp_done, input int ch0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_seen) break;
        end
        chk({nm, "_done_seen"}, done_seen, 1);
        chk({nm, "_done_cyc"}, done_rel, exp_done);
        chk({nm, "_sa_reset_cyc"}, first_rst, 1);
        chk({nm, "_beats"}, beats, k);
        chk({nm, "_sa_en_cnt"}, en_cnt, k + F);
        chk({nm, "_prime_cyc"}, first_ch, exp_done - N - 1 - stl);
        chk({nm, "_handshakes"}, hs, N);
        chk({nm, "_en_gap_bad"}, en_bad, 0);
        chk({nm, "_ch_stall_bad"}, ch_bad, 0);
        chk({nm, "_mode_bad"}, mode_bad, 0);
        chk({nm, "_sb_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({nm, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int ch_before, done_before;
        #3;
        chk("rst_outs", all_outs(), 0);
        @(negedge clk); #1; reset = 1;
        @(negedge clk);
        chk("idle_outs", all_outs(), 0);

        // Baseline: k=3, no stalls, done at 17.
        ch_before = ch_cnt;
        issue_start(3, 0, 0); finish_job("base", 3, 0, 17, 12);
        chk("base_ch_en_cnt", ch_cnt - ch_before, N);

        // Valid gaps: three extra FEED cycles.
        vpat = 1;
        issue_start(3, 1, 0); finish_job("gap", 3, 0, 20, 15);
        vpat = 0;

        // out_ready stalled 5 cycles at channel 2.
        stall_left = 5;
        issue_start(3, 0, 0); finish_job("stall", 3, 5, 22, 12);

        // k_len = 0 goes straight to FLUSH.
        issue_start(0, 1, 0); finish_job("k0", 0, 0, 14, 9);

        // k_len at its maximum: counter must not wrap.
        issue_start(255, 0, 0); finish_job("kmax", 255, 0, 3 + 255 + F + N, 0);

        // Abort on the third FLUSH cycle (cycle 7 of a k=3 job).
        done_before = done_total;
        issue_start(3, 1, 0);
        repeat (6) @(posedge clk);
        #1 abort = 1;
        @(negedge clk);
        chk("abort_zero_in", zero_in, 1'b0 ^ 1'b0);
        chk("abort_ch_reset", sa_ch_reset, 1);
        chk("abort_sa_en", sa_en, 0);
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort_busy_next", busy, 0);
        exp_q.delete();
        // Restart right away, with abort also high in the start cycle (IDLE).
        issue_start(2, 0, 1); finish_job("post_abort", 2, 0, 16, 0);
        chk("abort_done_count", done_total - done_before, 1);

        // Start with toggled mode during DRAIN must be ignored.
        issue_start(2, 1, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk); #1 start = 1; cfg_mode = 0;
        @(posedge clk); #1 start = 0;
        finish_job("mode_hold", 2, 0, 16, 0);

        // Reset mid-FEED clears outputs without waiting for a clock edge.
        issue_start(3, 1, 0);
        @(posedge clk); #2 reset = 0;
        #1 chk("async_rst_outs", all_outs(), 0);
        @(negedge clk); #1 reset = 1;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_idle", all_outs(), 0);
        issue_start(1, 0, 0); finish_job("post_rst", 1, 0, 3 + 1 + F + N, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sa_ctrl.md
# sa_ctrl

Sequencing controller for the output-stationary systolic array (N×N PE grid, 8×8 / 1×8 modes). It latches a job configuration and clears the array. It streams K input vectors from the operand buffer under a valid/ready handshake, then flushes the skew pipeline with zero operands. Finally it drains the result one channel per beat to the writeback stage through the array's channel-output counter.

## Interface
- `N`, 32: array rows = columns (array row_num/column_num).
- `K_W`, 16: width of accumulation-length field.
- `PE_LAT`, 1: PE register latency added to skew flush.
- `IDX_W`, $clog2(N): drain index width.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; forces IDLE and all outputs to 0.
- `start` in 1: job request pulse, sampled only in IDLE.
- `cfg_mode` in 1: 0 = 8×8 (row is channel), 1 = 1×8 (column is channel).
- `cfg_k_len` in K_W: number of input vectors to accumulate.
- `abort` in 1: synchronous job kill.
- `in_valid` in 1: operand buffer has row_in/column_in vector.
- `in_ready` out 1: controller consumes vector this cycle.
- `out_ready` in 1: writeback accepts current channel.
- `sa_en` out 1: array enable.
- `sa_mode` out 1: latched cfg_mode.
- `sa_reset` out 1: array PE accumulator clear (active-high, synchronous at array).
- `sa_ch_reset` out 1: array channel_out_reset.
- `sa_ch_en` out 1: array channel_out_en.
- `zero_in` out 1: operand mux selects zeros.
- `out_valid` out 1: array `out` holds channel `out_idx`.
- `out_idx` out IDX_W: channel index being presented.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle job-complete pulse.

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, PRIME, DRAIN, DONE.
- IDLE: all outputs 0. On `start`: latch cfg_mode → `sa_mode`, latch cfg_k_len → CLEAR.
- CLEAR (1 cycle): `sa_reset`=1, `sa_ch_reset`=1. Next state is FEED, or FLUSH if k_len==0.
- FEED: `in_ready`=1, `sa_en`=`in_valid`. A beat is accepted when in_valid&in_ready; count beats. After beat k_len → FLUSH. With in_valid=0, sa_en=0 (array frozen, no skew corruption).
- FLUSH: `sa_en`=1, `zero_in`=1 for exactly F = 2·(N−1)+PE_LAT cycles → PRIME.
- PRIME (1 cycle): `sa_ch_en`=1 (array counter −1 → 0), out_idx=0 → DRAIN.
- DRAIN: `out_valid`=1, `out_idx`=current index. On out_ready: `sa_ch_en`=1 and increment index. On index N−1 accepted: `sa_ch_en`=0, `sa_ch_reset`=1 → DONE. Without out_ready, hold index, sa_ch_en=0.
- DONE (1 cycle): `done`=1 → IDLE.
- `sa_mode` is constant from CLEAR through DONE. It is only reloaded on accepted start.
- `abort` in any non-IDLE state: that cycle `sa_ch_reset`=1, all other outputs 0, next state IDLE. No `done` is issued. Abort in IDLE is ignored.
- `start` while busy is ignored; it is not queued.
- Beat counter is K_W bits. k_len = 2^K_W−1 completes without wrap. FLUSH counter is wide enough for F.

## Timing
- Reset (async assert): state IDLE; all outputs 0, out_idx=0, counters 0. Release is synchronous to next clk edge.
- start sampled at edge t: CLEAR during t+1; first FEED cycle t+2.
- No stalls: done asserted at cycle t+1+1+K+F+1+N, i.e. total latency 3+K+F+N cycles from start to done (plus DONE cycle).
- out_idx and out_valid are registered state decodes. in_ready, sa_en, and sa_ch_en are combinational from state plus in_valid/out_ready only.
- Simultaneous abort and out_ready/in_valid: abort wins; no beat counted.
- Simultaneous start and abort in IDLE: start accepted.
- Reset mid-job: immediate IDLE. The array's own counter is not cleared by this block until the next CLEAR.

## Test plan
- N=4, PE_LAT=1, k_len=3, in_valid and out_ready always 1, start at cycle 0 -> sa_reset at cycle 1; sa_en for cycles 2–4 (feed) and 5–11 (F=7); sa_ch_en at 12; out_idx 0,1,2,3 on cycles 13–16; done at 17.
- Same job with in_valid low every other cycle -> exactly 3 accepted beats; sa_en never high in FEED while in_valid=0; done delayed by 3 cycles.
- out_ready low for 5 cycles at out_idx=2 -> out_idx holds 2, sa_ch_en=0 for those cycles, then 3; exactly 4 ready handshakes before done.
- k_len=0 -> CLEAR then FLUSH directly; 4 drain beats; done at cycle 14.
- abort during FLUSH cycle 3 -> same cycle sa_ch_reset=1 and sa_en=0; busy=0 next cycle; no done; a new start is accepted immediately.
- start asserted during DRAIN with cfg_mode toggled -> ignored; sa_mode unchanged until done; reset asserted mid-FEED -> all outputs 0 asynchronously.
